// File: rtl/reg_write_queue.sv
// reg_write_queue: a circular write-back queue in front of a 16-entry register array.
// Accepted writes drain one per cycle unless hold is set. The drain side presents
// a one-hot write enable and data. Read ports can look up the youngest pending
// write to a register.
module reg_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [3:0]               wr_reg,
    input  logic [15:0]              wr_data,
    output logic                     wr_ready,
    input  logic                     hold,
    output logic [15:0]              D,
    output logic [15:0]              WriteReg,
    input  logic [3:0]               rd_reg1,
    input  logic [3:0]               rd_reg2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [15:0]              fwd_data1,
    output logic [15:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]   wr_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [3:0]  rnum;
        logic [15:0] data;
    } entry_t;

    typedef struct packed {
        logic        hit;
        logic [15:0] data;
    } fwd_t;

    entry_t mem [DEPTH];
    ptr_t   head;
    ptr_t   tail;
    cnt_t   count;

    logic full;
    logic accept;
    logic push;
    logic pop;

    // wr_ready comes only from the registered count, so a pop in the same cycle
    // cannot open the queue to a new request while it is full.
    assign full     = (count == cnt_t'(DEPTH));
    assign wr_ready = !rst && !full;
    assign accept   = wr_valid && wr_ready;
    // A write to register 0 completes the handshake, but it is not stored.
    assign push     = accept && (wr_reg != 4'd0);
    assign pop      = !rst && (count != '0) && !hold;
    assign wr_count = count;

    // Pointer and occupancy bookkeeping. Reset takes priority over push and pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples values from before the edge, whatever order the statements are in.
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
            if (push) tail <= tail + ptr_t'(1);
            if (pop)  head <= head + ptr_t'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset. Only slots inside
        // [head, head+count) are ever read, and reset clears count.
        if (push) begin
            mem[tail] <= '{rnum: wr_reg, data: wr_data};
        end
    end

    // Drain port: present the head entry whenever a pop happens this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // holds its old value and no latch is inferred.
        WriteReg = '0;
        D        = '0;
        if (pop) begin
            WriteReg[mem[head].rnum] = 1'b1;
            D                        = mem[head].data;
        end
    end

    // Forwarding: scan from oldest to youngest so the last match wins. The scan
    // includes the head that is being drained this cycle.
    always_comb begin
        fwd_t f1;
        fwd_t f2;
        ptr_t idx;
        f1  = '0;
        f2  = '0;
        idx = '0;
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + ptr_t'(k);
                if (cnt_t'(k) < count) begin
                    if ((rd_reg1 != 4'd0) && (mem[idx].rnum == rd_reg1)) begin
                        f1.hit  = 1'b1;
                        f1.data = mem[idx].data;
                    end
                    if ((rd_reg2 != 4'd0) && (mem[idx].rnum == rd_reg2)) begin
                        f2.hit  = 1'b1;
                        f2.data = mem[idx].data;
                    end
                end
            end
        end
        fwd_hit1  = f1.hit;
        fwd_data1 = f1.data;
        fwd_hit2  = f2.hit;
        fwd_data2 = f2.data;
    end

endmodule
